// File: rtl/pdp8_pkg.sv
// pdp8_pkg
// Shared PDP-8 core definitions: memory port widths plus the state and
// owner encodings used by the main-memory arbiter.
package pdp8_pkg;

  localparam int ADDR_WIDTH = 12;
  localparam int DATA_WIDTH = 12;

  // Arbiter sequencing states; one memory access in flight at a time.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_ISSUE = 3'd1,
    RD_CAPT  = 3'd2,
    WR_ISSUE = 3'd3,
    DONE     = 3'd4
  } mem_arb_state_t;

  // Which requester owns the access currently in flight.
  typedef enum logic [0:0] {
    OWN_IFU  = 1'b0,
    OWN_EXEC = 1'b1
  } mem_owner_t;

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares the single main-memory port between the IFU (instruction reads)
// and the EXEC unit (operand reads and writes). One access is serialized at
// a time; EXEC has fixed priority over IFU, but after STARVE_LIMIT
// consecutive EXEC grants with an IFU request waiting, IFU is forced to win.
//
// Ports:
//   clk, reset              : rising-edge clock, synchronous active-high reset
//   ifu_rd_req/addr         : IFU read request (level) and address
//   ifu_rd_data/done        : IFU read data (held) and one-cycle done pulse
//   exec_rd_req/wr_req      : EXEC read / write requests (level)
//   exec_addr/wr_data       : EXEC address and write data
//   exec_rd_data/done       : EXEC read data (held) and one-cycle done pulse
//   mem_rd_req/wr_req       : memory read / write strobes
//   mem_addr/wr_data        : memory address and write data
//   mem_rd_data             : memory read data, valid the cycle after mem_rd_req
//   busy                    : high whenever the arbiter is not idle
module mem_arbiter
  import pdp8_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ifu_rd_req,
  input  logic [ADDR_WIDTH-1:0] ifu_rd_addr,
  output logic [DATA_WIDTH-1:0] ifu_rd_data,
  output logic                  ifu_rd_done,
  input  logic                  exec_rd_req,
  input  logic                  exec_wr_req,
  input  logic [ADDR_WIDTH-1:0] exec_addr,
  input  logic [DATA_WIDTH-1:0] exec_wr_data,
  output logic [DATA_WIDTH-1:0] exec_rd_data,
  output logic                  exec_done,
  output logic                  mem_rd_req,
  output logic                  mem_wr_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  busy
);

  localparam logic [2:0] STREAK_MAX = 3'(STARVE_LIMIT);

  mem_arb_state_t         state_r;
  mem_arb_state_t         next_state_s;
  mem_owner_t             owner_r;
  logic [2:0]             streak_r;

  logic                   exec_any_s;
  logic                   starved_s;
  logic                   grant_valid_s;
  mem_owner_t             grant_owner_s;
  logic                   grant_wr_s;
  logic [ADDR_WIDTH-1:0]  grant_addr_s;
  logic [2:0]             streak_next_s;

  logic [DATA_WIDTH-1:0]  ifu_rd_data_r;
  logic [DATA_WIDTH-1:0]  exec_rd_data_r;
  logic                   ifu_rd_done_r;
  logic                   exec_done_r;
  logic                   mem_rd_req_r;
  logic                   mem_wr_req_r;
  logic [ADDR_WIDTH-1:0]  mem_addr_r;
  logic [DATA_WIDTH-1:0]  mem_wr_data_r;
  logic                   busy_r;

  // Arbitration: pick the winner among pending requests and the next streak.
  always_comb begin
    exec_any_s    = exec_wr_req | exec_rd_req;
    starved_s     = (streak_r == STREAK_MAX);
    grant_valid_s = exec_any_s | ifu_rd_req;

    // IFU wins when EXEC is silent or when IFU has been starved long enough.
    if (ifu_rd_req && (!exec_any_s || starved_s)) begin
      grant_owner_s = OWN_IFU;
      grant_wr_s    = 1'b0;
      grant_addr_s  = ifu_rd_addr;
    end else begin
      grant_owner_s = OWN_EXEC;
      // A simultaneous write and read is served write-first; the read stays pending.
      grant_wr_s    = exec_wr_req;
      grant_addr_s  = exec_addr;
    end

    // The streak only counts EXEC wins that actually held off a waiting IFU.
    if (!grant_valid_s) begin
      streak_next_s = streak_r;
    end else if (grant_owner_s == OWN_IFU) begin
      streak_next_s = 3'd0;
    end else if (ifu_rd_req) begin
      if (starved_s) begin
        streak_next_s = streak_r;
      end else begin
        streak_next_s = streak_r + 3'd1;
      end
    end else begin
      streak_next_s = 3'd0;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; requests are only looked at in IDLE.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (grant_valid_s) begin
          if (grant_wr_s) begin
            next_state_s = WR_ISSUE;
          end else begin
            next_state_s = RD_ISSUE;
          end
        end else begin
          next_state_s = IDLE;
        end
      end
      RD_ISSUE: next_state_s = RD_CAPT;
      RD_CAPT:  next_state_s = DONE;
      WR_ISSUE: next_state_s = DONE;
      DONE:     next_state_s = IDLE;
      default:  next_state_s = IDLE;
    endcase
  end

  // Grant latch, streak counter and read-data capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_r        <= OWN_IFU;
      streak_r       <= 3'd0;
      mem_addr_r     <= '0;
      mem_wr_data_r  <= '0;
      ifu_rd_data_r  <= '0;
      exec_rd_data_r <= '0;
    end else begin
      if ((state_r == IDLE) && grant_valid_s) begin
        owner_r    <= grant_owner_s;
        streak_r   <= streak_next_s;
        mem_addr_r <= grant_addr_s;
        if (grant_wr_s) begin
          mem_wr_data_r <= exec_wr_data;
        end
      end
      // Only the owner's data register is touched.
      if (state_r == RD_CAPT) begin
        if (owner_r == OWN_IFU) begin
          ifu_rd_data_r <= mem_rd_data;
        end else begin
          exec_rd_data_r <= mem_rd_data;
        end
      end
    end
  end

  // Strobes, done pulses and busy are registered from the next state so
  // they line up exactly with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_rd_req_r  <= 1'b0;
      mem_wr_req_r  <= 1'b0;
      ifu_rd_done_r <= 1'b0;
      exec_done_r   <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      mem_rd_req_r  <= (next_state_s == RD_ISSUE);
      mem_wr_req_r  <= (next_state_s == WR_ISSUE);
      ifu_rd_done_r <= (next_state_s == DONE) && (owner_r == OWN_IFU);
      exec_done_r   <= (next_state_s == DONE) && (owner_r == OWN_EXEC);
      busy_r        <= (next_state_s != IDLE);
    end
  end

  assign ifu_rd_data  = ifu_rd_data_r;
  assign ifu_rd_done  = ifu_rd_done_r;
  assign exec_rd_data = exec_rd_data_r;
  assign exec_done    = exec_done_r;
  assign mem_rd_req   = mem_rd_req_r;
  assign mem_wr_req   = mem_wr_req_r;
  assign mem_addr     = mem_addr_r;
  assign mem_wr_data  = mem_wr_data_r;
  assign busy         = busy_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Self-checking bench for mem_arbiter: a memory environment, requester
// drivers obeying the done/drop protocol, and a transaction-level reference
// model that predicts grants, data and completion cycles into queues which
// a negedge monitor pops and compares.
module tb_mem_arbiter;

  localparam int AW    = 12;
  localparam int DW    = 12;
  localparam int LIMIT = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          ifu_rd_req = 1'b0;
  logic [AW-1:0] ifu_rd_addr = '0;
  logic [DW-1:0] ifu_rd_data;
  logic          ifu_rd_done;
  logic          exec_rd_req = 1'b0;
  logic          exec_wr_req = 1'b0;
  logic [AW-1:0] exec_addr = '0;
  logic [DW-1:0] exec_wr_data = '0;
  logic [DW-1:0] exec_rd_data;
  logic          exec_done;
  logic          mem_rd_req;
  logic          mem_wr_req;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wr_data;
  logic [DW-1:0] mem_rd_data = '0;
  logic          busy;

  always #5 clk = ~clk;

  mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .ifu_rd_req(ifu_rd_req), .ifu_rd_addr(ifu_rd_addr),
    .ifu_rd_data(ifu_rd_data), .ifu_rd_done(ifu_rd_done),
    .exec_rd_req(exec_rd_req), .exec_wr_req(exec_wr_req),
    .exec_addr(exec_addr), .exec_wr_data(exec_wr_data),
    .exec_rd_data(exec_rd_data), .exec_done(exec_done),
    .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req),
    .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
    .mem_rd_data(mem_rd_data), .busy(busy)
  );

  // Power-up memory contents; 12'h080 holds 12'h5A3 for the directed fetch.
  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    logic [AW-1:0] r;
    if (a == 12'h080) return 12'h5A3;
    r = a ^ 12'hA5C;
    return {r[4:0], r[11:5]};
  endfunction

  // Memory environment: one-cycle read latency, writes commit on the strobe.
  bit [DW-1:0] env_mem   [0:4095];
  bit          env_valid [0:4095];
  always @(posedge clk) begin
    if (mem_rd_req) mem_rd_data <= env_valid[mem_addr] ? env_mem[mem_addr] : init_val(mem_addr);
    if (mem_wr_req) begin
      env_mem[mem_addr]   <= mem_wr_data;
      env_valid[mem_addr] <= 1'b1;
    end
  end

  // ---------------- reference model + monitor ----------------
  typedef struct { logic [DW-1:0] data; int cyc; bit wr; } exp_t;
  exp_t ifu_q[$];
  exp_t exec_q[$];
  bit [DW-1:0] model_mem   [0:4095];
  bit          model_valid [0:4095];
  int  n_tests = 0;
  int  n_fail  = 0;
  int  cyc     = 0;
  int  wait_cnt = 0;
  int  streak_m = 0;
  bit  issue_chk = 1'b0;
  bit  issue_wr;
  logic [AW-1:0] issue_addr;
  logic [DW-1:0] issue_wdata;
  bit  streak_chk = 1'b0;
  logic [DW-1:0] last_ifu = '0;
  logic [DW-1:0] last_exec = '0;
  bit  ifu_done_seen = 1'b0;
  bit  exec_done_seen = 1'b0;
  bit  log_en = 1'b0;
  string order_log = "";

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a);
    return model_valid[a] ? model_mem[a] : init_val(a);
  endfunction

  always @(negedge clk) begin
    exp_t e;
    bit exec_any;
    cyc++;
    ifu_done_seen  = ifu_rd_done;
    exec_done_seen = exec_done;
    if (reset) begin
      ifu_q.delete();
      exec_q.delete();
      wait_cnt = 0; streak_m = 0; issue_chk = 1'b0; streak_chk = 1'b0;
      last_ifu = '0; last_exec = '0;
    end else begin
      chk("busy", {31'd0, busy}, {31'd0, wait_cnt != 0});
      if (issue_chk) begin
        chk("mem_rd_req", {31'd0, mem_rd_req}, {31'd0, !issue_wr});
        chk("mem_wr_req", {31'd0, mem_wr_req}, {31'd0, issue_wr});
        chk("mem_addr", {20'd0, mem_addr}, {20'd0, issue_addr});
        if (issue_wr) chk("mem_wr_data", {20'd0, mem_wr_data}, {20'd0, issue_wdata});
        issue_chk = 1'b0;
      end
      if (streak_chk) begin
        chk("streak", {29'd0, dut.streak_r}, streak_m);
        streak_chk = 1'b0;
      end
      if (ifu_rd_done) begin
        if (log_en) order_log = {order_log, "I"};
        if (ifu_q.size() == 0) chk("ifu_done_unexpected", 32'd1, 32'd0);
        else begin
          e = ifu_q.pop_front();
          chk("ifu_done_cycle", cyc, e.cyc);
          chk("ifu_rd_data", {20'd0, ifu_rd_data}, {20'd0, e.data});
          last_ifu = e.data;
          chk("exec_data_hold", {20'd0, exec_rd_data}, {20'd0, last_exec});
        end
      end
      if (exec_done) begin
        if (log_en) order_log = {order_log, "E"};
        if (exec_q.size() == 0) chk("exec_done_unexpected", 32'd1, 32'd0);
        else begin
          e = exec_q.pop_front();
          chk("exec_done_cycle", cyc, e.cyc);
          if (!e.wr) begin
            chk("exec_rd_data", {20'd0, exec_rd_data}, {20'd0, e.data});
            last_exec = e.data;
          end else begin
            chk("exec_data_hold_wr", {20'd0, exec_rd_data}, {20'd0, last_exec});
          end
          chk("ifu_data_hold", {20'd0, ifu_rd_data}, {20'd0, last_ifu});
        end
      end
      if (ifu_q.size() != 0 && ifu_q[0].cyc < cyc) begin
        chk("ifu_done_missing", 32'd0, 32'd1);
        void'(ifu_q.pop_front());
      end
      if (exec_q.size() != 0 && exec_q[0].cyc < cyc) begin
        chk("exec_done_missing", 32'd0, 32'd1);
        void'(exec_q.pop_front());
      end
      // Model: one access at a time; reads occupy 4 cycles, writes 3.
      if (wait_cnt > 0) begin
        wait_cnt--;
      end else begin
        exec_any = exec_wr_req || exec_rd_req;
        if (ifu_rd_req && (!exec_any || streak_m == LIMIT)) begin
          e.data = model_rd(ifu_rd_addr); e.cyc = cyc + 3; e.wr = 1'b0;
          ifu_q.push_back(e);
          streak_m = 0; wait_cnt = 3;
          issue_chk = 1'b1; issue_wr = 1'b0; issue_addr = ifu_rd_addr;
          streak_chk = 1'b1;
        end else if (exec_any) begin
          streak_m = ifu_rd_req ? ((streak_m < LIMIT) ? streak_m + 1 : LIMIT) : 0;
          issue_chk = 1'b1; issue_addr = exec_addr; issue_wdata = exec_wr_data;
          streak_chk = 1'b1;
          if (exec_wr_req) begin
            model_mem[exec_addr] = exec_wr_data;
            model_valid[exec_addr] = 1'b1;
            e.data = exec_wr_data; e.cyc = cyc + 2; e.wr = 1'b1;
            wait_cnt = 2; issue_wr = 1'b1;
          end else begin
            e.data = model_rd(exec_addr); e.cyc = cyc + 3; e.wr = 1'b0;
            wait_cnt = 3; issue_wr = 1'b0;
          end
          exec_q.push_back(e);
        end
      end
    end
  end

  // ---------------- requester drivers ----------------
  int ifu_todo = 0;
  int exec_todo = 0;
  bit rnd = 1'b0;
  int exec_op = 0;             // 0 read, 1 write, 2 write+read together
  logic [AW-1:0] exec_next_addr = '0;
  logic [DW-1:0] exec_next_data = '0;

  function automatic logic [AW-1:0] rand_addr();
    return ($urandom_range(0, 7) == 0) ? 12'h080 : 12'($urandom_range(0, 15));
  endfunction

  task automatic step();
    int op;
    @(posedge clk);
    #1;
    if (ifu_rd_req && ifu_done_seen) ifu_rd_req = 1'b0;
    if (!ifu_rd_req && ifu_todo > 0 && (!rnd || $urandom_range(0, 2) == 0)) begin
      ifu_rd_req = 1'b1;
      if (rnd) ifu_rd_addr = rand_addr();
      ifu_todo--;
    end
    if (exec_done_seen) begin
      if (exec_wr_req) exec_wr_req = 1'b0;
      else exec_rd_req = 1'b0;
    end
    if (!exec_wr_req && !exec_rd_req && exec_todo > 0 && (!rnd || $urandom_range(0, 2) == 0)) begin
      if (rnd) begin
        op = $urandom_range(0, 9);
        op = (op == 0) ? 2 : ((op < 5) ? 1 : 0);
        exec_addr    = rand_addr();
        exec_wr_data = 12'($urandom);
      end else begin
        op = exec_op;
        exec_addr    = exec_next_addr;
        exec_wr_data = exec_next_data;
      end
      exec_wr_req = (op != 0);
      exec_rd_req = (op != 1);
      exec_todo--;
    end
  endtask

  task automatic run_until_idle(input int max_cycles);
    int n = 0;
    while (n < max_cycles && (ifu_todo != 0 || exec_todo != 0 || ifu_rd_req || exec_rd_req ||
           exec_wr_req || ifu_q.size() != 0 || exec_q.size() != 0 || busy)) begin
      step();
      n++;
    end
    if (n >= max_cycles) chk("timeout", n, 0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    repeat (3) step();
    reset = 1'b0;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ifu_done", {31'd0, ifu_rd_done}, 32'd0);
    chk("rst_exec_done", {31'd0, exec_done}, 32'd0);
    chk("rst_mem_rd_req", {31'd0, mem_rd_req}, 32'd0);
    chk("rst_mem_wr_req", {31'd0, mem_wr_req}, 32'd0);
    chk("rst_mem_addr", {20'd0, mem_addr}, 32'd0);
    chk("rst_ifu_data", {20'd0, ifu_rd_data}, 32'd0);
    chk("rst_exec_data", {20'd0, exec_rd_data}, 32'd0);

    // IFU fetch of 12'h080 -> 12'h5A3
    ifu_rd_addr = 12'h080; ifu_todo = 1;
    run_until_idle(50);
    chk("ifu_fetch_5a3", {20'd0, ifu_rd_data}, 32'h5A3);

    // EXEC write 7FF to 010, then read it back
    exec_op = 1; exec_next_addr = 12'h010; exec_next_data = 12'h7FF; exec_todo = 1;
    run_until_idle(50);
    exec_op = 0; exec_todo = 1;
    run_until_idle(50);
    chk("exec_readback", {20'd0, exec_rd_data}, 32'h7FF);
    chk("ifu_unchanged", {20'd0, ifu_rd_data}, 32'h5A3);

    // Simultaneous IFU and EXEC reads: EXEC first, IFU 4 cycles later
    ifu_rd_addr = 12'h003; exec_next_addr = 12'h004; ifu_todo = 1; exec_todo = 1;
    run_until_idle(50);

    // Starvation guard
    order_log = ""; log_en = 1'b1;
    ifu_rd_addr = 12'h080; exec_next_addr = 12'h010; exec_op = 0;
    ifu_todo = 2; exec_todo = 8;
    run_until_idle(200);
    log_en = 1'b0;
    n_tests++;
    if (order_log != "EEEEIEEEEI") begin
      n_fail++;
      $display("FAIL grant_order: got %s expected EEEEIEEEEI", order_log);
    end

    // Write/read conflict on the same address
    exec_op = 2; exec_next_addr = 12'h00A; exec_next_data = 12'h3C3; exec_todo = 1;
    run_until_idle(50);
    chk("conflict_read", {20'd0, exec_rd_data}, 32'h3C3);

    // Reset in RD_CAPT, then the re-presented fetch completes normally
    ifu_rd_addr = 12'h080; ifu_todo = 1; rnd = 1'b0;
    step();              // IDLE samples
    step();              // RD_ISSUE
    step();              // RD_CAPT
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_ifu_done", {31'd0, ifu_rd_done}, 32'd0);
    chk("abort_mem_rd_req", {31'd0, mem_rd_req}, 32'd0);
    chk("abort_mem_addr", {20'd0, mem_addr}, 32'd0);
    chk("abort_ifu_data", {20'd0, ifu_rd_data}, 32'd0);
    run_until_idle(50);
    chk("refetch_data", {20'd0, ifu_rd_data}, 32'h5A3);

    // Randomized mix
    rnd = 1'b1; ifu_todo = 60; exec_todo = 60;
    run_until_idle(4000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter for the PDP-8 core that shares one main-memory port between the IFU (instruction reads) and the EXEC unit (operand reads and writes). It serializes one access at a time through a small state machine and returns read data to the owning requester with a done pulse. EXEC has fixed priority, with a starvation guard so instruction fetch always makes progress. It sits between the IFU/EXEC units and the memory model/array, which returns read data one cycle after `mem_rd_req`.

## Interface
- `STARVE_LIMIT`, 4: consecutive EXEC grants allowed while `ifu_rd_req` waits before IFU is forced to win. Range 1–7.
- `clk` in 1: single clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-high.
- `ifu_rd_req` in 1: IFU read request, level, held until `ifu_rd_done`.
- `ifu_rd_addr` in `ADDR_WIDTH`: IFU read address, stable while the request is high.
- `ifu_rd_data` out `DATA_WIDTH`: IFU read data, valid with `ifu_rd_done` and held until the next IFU completion.
- `ifu_rd_done` out 1: one-cycle completion pulse for IFU.
- `exec_rd_req`, `exec_wr_req` in 1 each: EXEC read and write requests, level.
- `exec_addr` in `ADDR_WIDTH`: EXEC address for either request type.
- `exec_wr_data` in `DATA_WIDTH`: EXEC write data.
- `exec_rd_data` out `DATA_WIDTH`: EXEC read data, held until the next EXEC read completion.
- `exec_done` out 1: one-cycle completion pulse for an EXEC read or write.
- `mem_rd_req` out 1: memory read strobe.
- `mem_wr_req` out 1: memory write strobe.
- `mem_addr` out `ADDR_WIDTH`: memory address.
- `mem_wr_data` out `DATA_WIDTH`: memory write data.
- `mem_rd_data` in `DATA_WIDTH`: memory read data, valid the cycle after `mem_rd_req`.
- `busy` out 1: high in every state except IDLE.

## Operation
- **States:** IDLE, RD_ISSUE, RD_CAPT, WR_ISSUE, DONE. All outputs are registered or decoded from the state register.
- **IDLE:** arbitrate among the pending requests and latch the winner's owner, type, address and write data.
  - Read winner → RD_ISSUE. Write winner → WR_ISSUE.
  - No request pending → stay in IDLE.
- **Priority:**
  - `exec_wr_req` beats `exec_rd_req`. Both high together is a protocol violation; the write is served and the read stays pending.
  - EXEC beats IFU, unless `streak == STARVE_LIMIT`; then IFU wins.
- **Streak counter (3 bits):**
  - Increments on each EXEC grant made while `ifu_rd_req` is high.
  - Clears on an IFU grant.
  - Clears on an EXEC grant made while `ifu_rd_req` is low.
  - Saturates at `STARVE_LIMIT`.
- **RD_ISSUE:** `mem_rd_req` = 1, `mem_addr` = latched address → RD_CAPT.
- **RD_CAPT:** capture `mem_rd_data` into the owner's data register only → DONE.
- **WR_ISSUE:** `mem_wr_req` = 1 with latched address and data → DONE.
- **DONE:** pulse the owner's done for one cycle → IDLE.
- **Requester rule:** a requester samples done high and drops its request (or presents a new one) in the following cycle. The arbiter does not sample requests in DONE.
- **Non-owner isolation:** the data register and done pulse of the non-owner never change.
- **Reset (including mid-transaction):**
  - State → IDLE; streak → 0.
  - All strobes, done pulses, `busy` and data registers → 0; `mem_addr` and `mem_wr_data` → 0.
  - No done is issued for the aborted access. A write whose `mem_wr_req` already fired stays committed in memory.

## Timing
- Requests are sampled in cycle 0 (IDLE).
- **Read:** `mem_rd_req` in cycle 1, memory data in cycle 2, `*_done` plus data in cycle 3. Request-to-done latency is 3 cycles.
- **Write:** `mem_wr_req` in cycle 1, `exec_done` in cycle 2.
- **Throughput:** the next arbitration is in the cycle after DONE. Back-to-back reads complete every 4 cycles; back-to-back writes every 3 cycles.
- `busy` rises in cycle 1 and falls in the cycle after DONE.
- `mem_addr` and `mem_wr_data` are stable from the ISSUE state through DONE.

## Structure
- **In `pdp8_pkg`:**
  - `ADDR_WIDTH` and `DATA_WIDTH` (12/12), already present.
  - `typedef enum` `mem_arb_state_t` {IDLE, RD_ISSUE, RD_CAPT, WR_ISSUE, DONE}.
  - `typedef enum` `mem_owner_t` {OWN_IFU, OWN_EXEC}.
- **Sub-modules:** none. The FSM, arbitration logic and streak counter live in one module, roughly 200 lines.

## Test plan
- **IFU read:** IFU reads addr 12'h080 with memory holding 12'h5A3 → `mem_rd_req` in cycle 1, `ifu_rd_done` with `ifu_rd_data` = 12'h5A3 in cycle 3, `exec_done` never asserts.
- **EXEC write then read-back:** EXEC writes 12'h7FF to addr 12'h010 → `exec_done` in cycle 2. A following EXEC read of 12'h010 → `exec_rd_data` = 12'h7FF. `ifu_rd_data` is unchanged throughout.
- **Simultaneous requests:** `ifu_rd_req` and `exec_rd_req` both high in the same cycle → EXEC is served first; IFU completes 4 cycles after `exec_done`.
- **Starvation guard:** EXEC requests held continuously and IFU held high, with `STARVE_LIMIT` = 4 → grant order is exactly E,E,E,E,I,E,E,E,E,I. The streak counter reads 0 after each IFU grant.
- **Write/read conflict:** `exec_wr_req` and `exec_rd_req` both high → the write is served first, then the read, with the data-register writes in the same order.
- **Reset mid-read:** reset asserted in RD_CAPT → next cycle the state is IDLE, all outputs are 0 and there is no done pulse. A request re-presented after reset completes normally with 3-cycle latency.
